// File: rtl/measure_scheduler.sv
// Periodic ultrasonic ranging: trigger pulse, echo-width capture with timeout, holdoff to the period.
// Reports land one cycle after the terminating echo condition; MEASURE_SCHEDULER_AVG4_EN reports the mean of the last 4 widths.
module measure_scheduler #(
   parameter int unsigned TRIG_CYCLES    = 120,
   parameter int unsigned PERIOD_CYCLES  = 720000,
   parameter int unsigned TIMEOUT_CYCLES = 456000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        echo,
   output logic        trig,
   output logic        busy,
   output logic [31:0] result_cycles,
   output logic        result_valid,
   output logic        result_timeout
);

   localparam logic [31:0] TRIG_LAST   = TRIG_CYCLES - 1;
   localparam logic [31:0] PERIOD_LAST = PERIOD_CYCLES - 1;
   localparam logic [31:0] TMO_LAST    = TIMEOUT_CYCLES - 1;
   localparam logic [31:0] TMO_VAL     = TIMEOUT_CYCLES;
   localparam logic [31:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

   state_t      state_q, state_d;
   logic        echo_s1_q, echo_s_q, armed_q;
   logic [31:0] cnt_q, cnt_d, period_q, period_d;
   logic        rep_vld, rep_to;
   logic        trig_q, busy_q;
   logic        res_vld_q, res_vld_d, res_to_q, res_to_d;
   logic [31:0] res_cyc_q, res_cyc_d;
`ifdef MEASURE_SCHEDULER_AVG4_EN
   logic [2:0][31:0] win_q, win_d;
   logic [1:0]       nsamp_q, nsamp_d;
   logic [33:0]      sum;
`endif

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = sat_inc(period_q);
      rep_vld  = 1'b0;
      rep_to   = 1'b0;
      case (state_q)
         IDLE: if (enable && armed_q) state_d = TRIG;
         TRIG: begin
            if (cnt_q >= TRIG_LAST) begin
               state_d = WAIT_RISE;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         WAIT_RISE: begin
            if (echo_s_q) begin
               state_d = MEASURE;
               cnt_d   = 32'd1;
            end else if (cnt_q >= TMO_LAST) begin
               state_d = HOLDOFF;
               rep_vld = 1'b1;
               rep_to  = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         MEASURE: begin
            // cnt_q holds the number of high samples seen so far
            if (!echo_s_q) begin
               state_d = HOLDOFF;
               rep_vld = 1'b1;
            end else if (cnt_q >= TMO_LAST) begin
               state_d = HOLDOFF;
               rep_vld = 1'b1;
               rep_to  = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         HOLDOFF: begin
            if (!enable)                     state_d = IDLE;
            else if (period_q >= PERIOD_LAST) state_d = TRIG;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == TRIG && state_q != TRIG) begin
         period_d = '0;
         cnt_d    = '0;
      end
   end

   always_comb begin
      res_vld_d = 1'b0;
      res_cyc_d = res_cyc_q;
      res_to_d  = res_to_q;
`ifdef MEASURE_SCHEDULER_AVG4_EN
      win_d   = win_q;
      nsamp_d = nsamp_q;
      sum     = {2'b00, cnt_q} + {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]};
`endif
      if (rep_vld && rep_to) begin
         res_vld_d = 1'b1;
         res_cyc_d = TMO_VAL;
         res_to_d  = 1'b1;
      end else if (rep_vld) begin
`ifdef MEASURE_SCHEDULER_AVG4_EN
         win_d = {win_q[1:0], cnt_q};
         if (nsamp_q == 2'd3) begin
            res_vld_d = 1'b1;
            res_cyc_d = sum[33:2];
            res_to_d  = 1'b0;
         end else begin
            nsamp_d = nsamp_q + 2'd1;
         end
`else
         res_vld_d = 1'b1;
         res_cyc_d = cnt_q;
         res_to_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         echo_s1_q <= 1'b0;
         echo_s_q  <= 1'b0;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         period_q  <= '0;
         trig_q    <= 1'b0;
         busy_q    <= 1'b0;
         res_vld_q <= 1'b0;
         res_cyc_q <= '0;
         res_to_q  <= 1'b0;
`ifdef MEASURE_SCHEDULER_AVG4_EN
         win_q     <= '0;
         nsamp_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         echo_s1_q <= echo;
         echo_s_q  <= echo_s1_q;
         armed_q   <= 1'b1;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         trig_q    <= (state_d == TRIG);
         busy_q    <= (state_d != IDLE);
         res_vld_q <= res_vld_d;
         res_cyc_q <= res_cyc_d;
         res_to_q  <= res_to_d;
`ifdef MEASURE_SCHEDULER_AVG4_EN
         win_q     <= win_d;
         nsamp_q   <= nsamp_d;
`endif
      end
   end

   assign trig           = trig_q;
   assign busy           = busy_q;
   assign result_cycles  = res_cyc_q;
   assign result_valid   = res_vld_q;
   assign result_timeout = res_to_q;

endmodule
